// File: rtl/rcd_reg_pkg.sv
// Shared types and default constants for the register-bus initiator.
package rcd_reg_pkg;

    // Response status returned with every completed command.
    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_ERR     = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_e;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10,
        RSP  = 2'b11
    } state_e;

    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 32;
    localparam int DEF_MAX_RETRY      = 2;

endpackage

// File: rtl/rcd_reg_timeout_ctr.sv
// Per-attempt request-cycle counter. Counts REQ cycles without a responder
// answer; expired is high during the last permitted cycle of an attempt.
// The counter saturates instead of wrapping.
module rcd_reg_timeout_ctr
    import rcd_reg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;

    // Clear has priority; count up while enabled and hold at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/rcd_reg_initiator.sv
// Register-bus initiator: accepts one command, drives a level request on the
// register bus until ack/err/timeout, then holds a response until consumed.
// Optional feature: define RCD_REG_INIT_RETRY_EN to re-issue a request after
// err_i (up to MAX_RETRY times, one GAP cycle between attempts).
//
// Handshakes: cmd_* transfers on a cycle with cmd_valid_i && cmd_ready_o;
// rsp_* transfers on a cycle with rsp_valid_o && rsp_ready_i. A valid side
// never withdraws or changes its payload before the transfer completes.
module rcd_reg_initiator
    import rcd_reg_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_status_o,
    output logic [1:0]            rsp_retries_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic                  reg_rd_req_o,
    output logic                  reg_wr_req_o,
    output logic [DATA_WIDTH-1:0] reg_wr_data_o,
    input  logic [DATA_WIDTH-1:0] reg_rd_data_i,
    input  logic                  ack_i,
    input  logic                  err_i
);

`ifdef RCD_REG_INIT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [1:0] MAX_RETRY_W = MAX_RETRY[1:0];

    state_e                state_q, state_d;
    logic                  is_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    rsp_status_e           status_q, status_d;
    logic [1:0]            retry_q;
    logic                  rsp_load;
    logic                  retry_ok;
    logic                  accept;
    logic                  in_req;
    logic                  to_expired;

    assign accept   = cmd_valid_i && (state_q == IDLE);
    assign in_req   = (state_q == REQ);
    // Without the retry feature this is constant 0, so GAP cannot be reached
    // and retry_q never leaves its reset value.
    assign retry_ok = RETRY_EN && (retry_q < MAX_RETRY_W);

    rcd_reg_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (!in_req),
        .enable (in_req),
        .expired(to_expired)
    );

    // Next-state and response-capture decisions.
    always_comb begin
        state_d  = state_q;
        rsp_load = 1'b0;
        rdata_d  = rdata_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) state_d = REQ;
            end
            REQ: begin
                if (err_i) begin
                    if (retry_ok) begin
                        state_d = GAP;
                    end else begin
                        rsp_load = 1'b1;
                        status_d = RSP_ERR;
                        rdata_d  = '0;
                        state_d  = RSP;
                    end
                end else if (ack_i) begin
                    rsp_load = 1'b1;
                    status_d = RSP_OK;
                    rdata_d  = is_write_q ? '0 : reg_rd_data_i;
                    state_d  = RSP;
                end else if (to_expired) begin
                    rsp_load = 1'b1;
                    status_d = RSP_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = RSP;
                end
            end
            GAP: begin
                state_d = REQ;
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Command capture on accept, response capture when an attempt resolves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= RSP_OK;
        end else if (accept) begin
            is_write_q <= cmd_write_i;
            addr_q     <= cmd_addr_i;
            wdata_q    <= cmd_wdata_i;
            rdata_q    <= '0;
            status_q   <= RSP_OK;
        end else if (rsp_load) begin
            rdata_q    <= rdata_d;
            status_q   <= status_d;
        end
    end

    // Retry counter: cleared per command, bumped on each re-issued attempt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retry_q <= 2'b00;
        end else if (accept) begin
            retry_q <= 2'b00;
        end else if (in_req && err_i && retry_ok) begin
            retry_q <= retry_q + 2'd1;
        end
    end

    // Bus outputs are purely decoded from state so reset drops them at once.
    assign cmd_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RSP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_status_o  = status_q;
    assign rsp_retries_o = RETRY_EN ? retry_q : 2'b00;
    assign reg_rd_req_o  = in_req && !is_write_q;
    assign reg_wr_req_o  = in_req && is_write_q;
    assign reg_addr_o    = in_req ? addr_q : '0;
    assign reg_wr_data_o = in_req ? wdata_q : '0;

endmodule

// File: tb/tb_rcd_reg_initiator.sv
// Self-checking bench for rcd_reg_initiator. Honours RCD_REG_INIT_RETRY_EN
// so the same bench covers both builds.
module tb_rcd_reg_initiator;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 32;
    localparam int MR = 2;
`ifdef RCD_REG_INIT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    // Responder behaviour per attempt.
    localparam int K_SILENT = 0;
    localparam int K_ACK    = 1;
    localparam int K_ERR    = 2;
    localparam int K_BOTH   = 3;

    logic          clk_i;
    logic          rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic [1:0]    rsp_status_o;
    logic [1:0]    rsp_retries_o;
    logic [AW-1:0] reg_addr_o;
    logic          reg_rd_req_o;
    logic          reg_wr_req_o;
    logic [DW-1:0] reg_wr_data_o;
    logic [DW-1:0] reg_rd_data_i;
    logic          ack_i;
    logic          err_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    rcd_reg_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_status_o(rsp_status_o), .rsp_retries_o(rsp_retries_o),
        .reg_addr_o(reg_addr_o), .reg_rd_req_o(reg_rd_req_o), .reg_wr_req_o(reg_wr_req_o),
        .reg_wr_data_o(reg_wr_data_o), .reg_rd_data_i(reg_rd_data_i),
        .ack_i(ack_i), .err_i(err_i)
    );

    // Clock and reset defaults.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int pick_kind();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return K_SILENT;
        if (r <= 2) return K_ERR;
        if (r == 3) return K_BOTH;
        return K_ACK;
    endfunction

    // Reference model: walk the attempts the responder will produce.
    function automatic void predict(input logic wr, input logic [DW-1:0] rdval,
                                    input int k0, input int k1, input int k2,
                                    input int d0, input int d1, input int d2,
                                    output logic [1:0] st, output logic [DW-1:0] rd,
                                    output logic [1:0] rt, output int attempts,
                                    output int last_len);
        int used;
        int k;
        int d;
        used = 0; st = 2'b00; rd = '0; attempts = 0; last_len = 0;
        for (int a = 0; a < 8; a++) begin
            k = (a == 0) ? k0 : (a == 1) ? k1 : k2;
            d = (a == 0) ? d0 : (a == 1) ? d1 : d2;
            attempts = a + 1;
            if (k == K_SILENT) begin
                st = 2'b10; rd = '0; last_len = TO;
                break;
            end
            last_len = d + 1;
            if (k == K_ACK) begin
                st = 2'b00; rd = wr ? '0 : rdval;
                break;
            end
            if (RETRY_EN && used < MR) begin
                used++;
                continue;
            end
            st = 2'b01; rd = '0;
            break;
        end
        rt = used[1:0];
    endfunction

    // Driver + bus responder for one command; reports what it observed.
    task automatic exec_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdval,
                            input int k0, input int k1, input int k2,
                            input int d0, input int d1, input int d2, input int hold,
                            output logic [1:0] st, output logic [DW-1:0] rd,
                            output logic [1:0] rt, output int attempts,
                            output int last_len, output int lat, output int bad,
                            output int gap_bad, output bit tmo);
        bit in_req_prev;
        bit done;
        int ac;
        int gap_run;
        int cyc;
        int k;
        int d;
        attempts = 0; last_len = 0; lat = 0; bad = 0; gap_bad = 0; tmo = 1'b0;
        in_req_prev = 1'b0; done = 1'b0; ac = 0; gap_run = 0;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
        if (cmd_ready_o !== 1'b1) bad++;
        step();
        cmd_valid_i = 1'b0; cmd_addr_i = AW'($urandom); cmd_wdata_i = DW'($urandom);
        cyc = 1;
        while (!done && cyc < 400) begin
            ack_i = 1'b0; err_i = 1'b0; reg_rd_data_i = DW'($urandom);
            if (rsp_valid_o === 1'b1) begin
                done = 1'b1; lat = cyc;
            end else if (reg_rd_req_o === 1'b1 || reg_wr_req_o === 1'b1) begin
                if (!in_req_prev) begin
                    attempts++; ac = 0;
                    if (attempts > 1 && gap_run != 1) gap_bad++;
                end
                if (reg_rd_req_o === wr || reg_wr_req_o !== wr ||
                    reg_addr_o !== addr || reg_wr_data_o !== wdata) bad++;
                k = (attempts == 1) ? k0 : (attempts == 2) ? k1 : k2;
                d = (attempts == 1) ? d0 : (attempts == 2) ? d1 : d2;
                if (k != K_SILENT && ac == d) begin
                    if (k == K_ACK || k == K_BOTH) begin ack_i = 1'b1; reg_rd_data_i = rdval; end
                    if (k == K_ERR || k == K_BOTH) err_i = 1'b1;
                end
                ac++; last_len = ac; in_req_prev = 1'b1;
            end else begin
                if (reg_addr_o !== '0 || reg_wr_data_o !== '0) bad++;
                ack_i = 1'($urandom); err_i = 1'($urandom);
                gap_run = in_req_prev ? 1 : gap_run + 1;
                in_req_prev = 1'b0;
            end
            if (!done) begin step(); cyc++; end
        end
        if (!done) tmo = 1'b1;
        ack_i = 1'b0; err_i = 1'b0;
        st = rsp_status_o; rd = rsp_rdata_o; rt = rsp_retries_o;
        for (int i = 0; i < hold; i++) begin
            rsp_ready_i = 1'b0; cmd_valid_i = 1'b1; cmd_addr_i = AW'($urandom);
            step();
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== st || rsp_rdata_o !== rd ||
                rsp_retries_o !== rt || cmd_ready_o !== 1'b0 ||
                reg_rd_req_o !== 1'b0 || reg_wr_req_o !== 1'b0) bad++;
        end
        cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 ||
            reg_rd_req_o !== 1'b0 || reg_wr_req_o !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; rsp_ready_i = 1'b0; reg_rd_data_i = '0; ack_i = 1'b0; err_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready_o); end
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_o); end
        n_checks++; if (rsp_rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata_o); end
        n_checks++; if (rsp_status_o !== 2'b00 || rsp_retries_o !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b/%b exp 00/00", rsp_status_o, rsp_retries_o); end
        n_checks++; if ({reg_rd_req_o, reg_wr_req_o} !== 2'b00 || reg_addr_o !== '0 || reg_wr_data_o !== '0) begin n_fail++; $display("FAIL reset_reg_bus got %b%b %h %h exp all 0", reg_rd_req_o, reg_wr_req_o, reg_addr_o, reg_wr_data_o); end
        @(negedge clk_i) rst_ni = 1'b1;
        step();
        n_checks++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release got ready %b valid %b exp 1 0", cmd_ready_o, rsp_valid_o); end
    endtask

    task automatic test_read_basic();
        logic [1:0] st, rt; logic [DW-1:0] rd; int att, len, lat, bad, gb; bit tmo;
        exec_cmd(1'b0, 8'h02, 16'h1234, 16'hBEEF, K_ACK, K_ACK, K_ACK, 0, 0, 0, 0,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL read_latency got %0d exp 2", lat); end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL read_rdata got %h exp beef", rd); end
        n_checks++; if (st !== 2'b00 || rt !== 2'b00) begin n_fail++; $display("FAIL read_status got %b/%b exp 00/00", st, rt); end
        n_checks++; if (att !== 1 || bad !== 0 || tmo !== 1'b0) begin n_fail++; $display("FAIL read_bus got att %0d bad %0d tmo %0d exp 1 0 0", att, bad, tmo); end
    endtask

    task automatic test_err_retry();
        logic [1:0] st, rt, est, ert; logic [DW-1:0] rd, erd; int att, len, lat, bad, gb, eatt, elen; bit tmo;
        predict(1'b1, 16'h0, K_ERR, K_ERR, K_ERR, 0, 0, 0, est, erd, ert, eatt, elen);
        exec_cmd(1'b1, 8'h01, 16'hA5A5, 16'h0, K_ERR, K_ERR, K_ERR, 0, 0, 0, 1,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (st !== 2'b01 || rd !== '0) begin n_fail++; $display("FAIL err_status got %b %h exp 01 0000", st, rd); end
        n_checks++; if (rt !== ert || att !== eatt) begin n_fail++; $display("FAIL err_retries got rt %0d att %0d exp %0d %0d", rt, att, ert, eatt); end
        n_checks++; if (gb !== 0 || bad !== 0 || tmo !== 1'b0) begin n_fail++; $display("FAIL err_gaps got gap_bad %0d bad %0d tmo %0d exp 0 0 0", gb, bad, tmo); end
    endtask

    task automatic test_timeout();
        logic [1:0] st, rt; logic [DW-1:0] rd; int att, len, lat, bad, gb; bit tmo;
        exec_cmd(1'b0, 8'h05, 16'h0, 16'h5555, K_SILENT, K_SILENT, K_SILENT, 0, 0, 0, 0,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (st !== 2'b10 || rd !== 16'h0000) begin n_fail++; $display("FAIL timeout_status got %b %h exp 10 0000", st, rd); end
        n_checks++; if (len !== TO || att !== 1) begin n_fail++; $display("FAIL timeout_len got %0d att %0d exp %0d 1", len, att, TO); end
        n_checks++; if (bad !== 0 || tmo !== 1'b0) begin n_fail++; $display("FAIL timeout_bus got bad %0d tmo %0d exp 0 0", bad, tmo); end
    endtask

    task automatic test_ack_last_cycle();
        logic [1:0] st, rt; logic [DW-1:0] rd; int att, len, lat, bad, gb; bit tmo;
        exec_cmd(1'b0, 8'h33, 16'h0, 16'h7E57, K_ACK, K_ACK, K_ACK, TO - 1, 0, 0, 0,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (st !== 2'b00 || rd !== 16'h7E57) begin n_fail++; $display("FAIL ack_last got %b %h exp 00 7e57", st, rd); end
        n_checks++; if (len !== TO || bad !== 0) begin n_fail++; $display("FAIL ack_last_len got %0d bad %0d exp %0d 0", len, bad, TO); end
    endtask

    task automatic test_ack_err_same();
        logic [1:0] st, rt, est, ert; logic [DW-1:0] rd, erd; int att, len, lat, bad, gb, eatt, elen; bit tmo;
        predict(1'b0, 16'h1111, K_BOTH, K_BOTH, K_BOTH, 0, 0, 0, est, erd, ert, eatt, elen);
        exec_cmd(1'b0, 8'h09, 16'h0, 16'h1111, K_BOTH, K_BOTH, K_BOTH, 0, 0, 0, 0,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (st !== est || rd !== erd || rt !== ert) begin n_fail++; $display("FAIL ack_err_same got %b %h %0d exp %b %h %0d", st, rd, rt, est, erd, ert); end
        n_checks++; if (att !== eatt || bad !== 0) begin n_fail++; $display("FAIL ack_err_attempts got %0d bad %0d exp %0d 0", att, bad, eatt); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] st, rt; logic [DW-1:0] rd; int att, len, lat, bad, gb; bit tmo;
        exec_cmd(1'b1, 8'h40, 16'hC0DE, 16'h0, K_ACK, K_ACK, K_ACK, 2, 0, 0, 5,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (bad !== 0 || st !== 2'b00 || rd !== '0) begin n_fail++; $display("FAIL b2b_first got bad %0d st %b rd %h exp 0 00 0000", bad, st, rd); end
        exec_cmd(1'b0, 8'h41, 16'h0, 16'h2468, K_ACK, K_ACK, K_ACK, 0, 0, 0, 0,
                 st, rd, rt, att, len, lat, bad, gb, tmo);
        n_checks++; if (lat !== 2 || rd !== 16'h2468 || bad !== 0) begin n_fail++; $display("FAIL b2b_second got lat %0d rd %h bad %0d exp 2 2468 0", lat, rd, bad); end
    endtask

    task automatic test_reset_mid_req();
        int bad;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h07;
        step();
        cmd_valid_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
        step();
        step();
        n_checks++; if (reg_rd_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req got %b exp 1", reg_rd_req_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++; if (reg_rd_req_o !== 1'b0 || reg_addr_o !== '0) begin n_fail++; $display("FAIL rst_async_drop got %b %h exp 0 00", reg_rd_req_o, reg_addr_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || reg_rd_req_o !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_no_response got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_random();
        logic [1:0] st, rt, est, ert; logic [DW-1:0] rd, erd, rdval, exp_rd;
        int att, len, lat, bad, gb, eatt, elen; bit tmo; logic wr;
        int k0, k1, k2, d0, d1, d2;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom); rdval = DW'($urandom);
            k0 = pick_kind(); k1 = pick_kind(); k2 = pick_kind();
            d0 = $urandom_range(0, 6); d1 = $urandom_range(0, 6); d2 = $urandom_range(0, 6);
            predict(wr, rdval, k0, k1, k2, d0, d1, d2, est, erd, ert, eatt, elen);
            exp_q.push_back(erd);
            exec_cmd(wr, AW'($urandom), DW'($urandom), rdval, k0, k1, k2, d0, d1, d2,
                     $urandom_range(0, 3), st, rd, rt, att, len, lat, bad, gb, tmo);
            exp_rd = exp_q.pop_front();
            n_checks++; if (st !== est || rd !== exp_rd || rt !== ert) begin n_fail++; $display("FAIL rand_rsp[%0d] got %b %h %0d exp %b %h %0d", n, st, rd, rt, est, exp_rd, ert); end
            n_checks++; if (att !== eatt || len !== elen) begin n_fail++; $display("FAIL rand_attempts[%0d] got %0d/%0d exp %0d/%0d", n, att, len, eatt, elen); end
            n_checks++; if (bad !== 0 || gb !== 0 || tmo !== 1'b0) begin n_fail++; $display("FAIL rand_bus[%0d] got bad %0d gap %0d tmo %0d exp 0 0 0", n, bad, gb, tmo); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_err_retry();
        test_timeout();
        test_ack_last_cycle();
        test_ack_err_same();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rcd_reg_initiator.md
RCD_REG_INITIATOR -- requirements
Module: rcd_reg_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the register address width.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the register data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 32, SHALL set the maximum number of request cycles per attempt (minimum 2).
REQ-004 Parameter MAX_RETRY, default 2, SHALL set the maximum number of re-issues after err_i.
REQ-005 Ports SHALL be:
  clk_i  in  1  clock
  rst_ni  in  1  reset, asynchronous, active-low
  cmd_valid_i  in  1  command offered
  cmd_ready_o  out  1  command accepted when valid&ready
  cmd_write_i  in  1  1=write, 0=read
  cmd_addr_i  in  ADDR_WIDTH  target register
  cmd_wdata_i  in  DATA_WIDTH  write data
  rsp_valid_o  out  1  response available
  rsp_ready_i  in  1  response consumed when valid&ready
  rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes or failures)
  rsp_status_o  out  2  rsp_status_e code
  rsp_retries_o  out  2  re-issues used
  reg_addr_o  out  ADDR_WIDTH  register bus address
  reg_rd_req_o  out  1  read request level
  reg_wr_req_o  out  1  write request level
  reg_wr_data_o  out  DATA_WIDTH  write data
  reg_rd_data_i  in  DATA_WIDTH  read data, valid in ack_i cycle
  ack_i  in  1  responder acknowledge
  err_i  in  1  responder error

Function
REQ-006 FSM states SHALL be IDLE, REQ, GAP, RSP; cmd_ready_o SHALL be 1 only in IDLE.
REQ-007 IDLE: on cmd_valid_i&cmd_ready_o, write, address and data SHALL be captured, retry count cleared, and next state REQ.
REQ-008 REQ: exactly one of reg_rd_req_o/reg_wr_req_o SHALL be 1, and reg_addr_o/reg_wr_data_o SHALL hold the captured values stable.
REQ-009 Outside REQ, both request outputs SHALL be 0 and reg_addr_o, reg_wr_data_o SHALL be 0.
REQ-010 REQ with ack_i=1, err_i=0: rsp_rdata_o SHALL capture reg_rd_data_i (reads) or 0 (writes), status RSP_OK, next RSP.
REQ-011 REQ with err_i=1 (err wins over simultaneous ack_i): if retry is permitted and retry count < MAX_RETRY, count SHALL increment and next state GAP; otherwise status RSP_ERR, next RSP.
REQ-012 REQ with neither input for TIMEOUT_CYCLES consecutive cycles: status RSP_TIMEOUT, next RSP; ack_i in the final cycle SHALL take priority over the timeout.
REQ-013 Timeout counter SHALL clear on every REQ entry, and SHALL be $clog2(TIMEOUT_CYCLES)+1 bits wide with no wrap.
REQ-014 GAP SHALL last exactly one cycle with requests deasserted, then return to REQ.
REQ-015 RSP: rsp_valid_o=1 and all rsp_* outputs SHALL be held stable until rsp_ready_i; then next state IDLE.
REQ-016 Latency: command accepted at cycle T, request asserted at T+1, and with ack at T+1, rsp_valid_o SHALL be asserted at T+2.
REQ-017 ack_i/err_i SHALL be ignored outside REQ.
REQ-018 Back-to-back commands SHALL be separated on the bus by at least one idle cycle, guaranteed by the RSP and IDLE states.

Reset
REQ-019 Asynchronous reset SHALL force state IDLE, all counters 0, and rsp_valid_o, rsp_rdata_o, rsp_status_o, rsp_retries_o, reg_* outputs to 0, with cmd_ready_o=1.
REQ-020 Reset asserted mid-REQ SHALL drop request outputs in the same cycle, asynchronously, and SHALL discard the in-flight command with no response.

Configuration
REQ-021 With RCD_REG_INIT_RETRY_EN defined, retry per REQ-011 SHALL be active; without it, every err_i SHALL produce RSP_ERR immediately, GAP SHALL be unreachable, and rsp_retries_o SHALL be tied to 0.

Structure
REQ-022 Package rcd_reg_pkg SHALL hold the rsp_status_e encoding (RSP_OK=2'b00, RSP_ERR=2'b01, RSP_TIMEOUT=2'b10), the FSM state enum, and the default parameter constants.
REQ-023 The timeout counter SHALL be a sub-module rcd_reg_timeout_ctr with clear, enable, and expired signals.

Verification
REQ-024 Read addr 0x02, responder returns 0xBEEF with ack_i in the first request cycle -> rsp_valid_o at T+2, rdata 0xBEEF, RSP_OK, retries 0.
REQ-025 Write addr 0x01, err_i held high, retry enabled -> three request attempts separated by 1-cycle gaps, then RSP_ERR, retries 2.
REQ-026 Read addr 0x05, responder silent -> request held exactly 32 cycles, then RSP_TIMEOUT with rdata 0x0000.
REQ-027 Two queued commands, rsp_ready_i held low for 5 cycles -> response held stable, cmd_ready_o low, and the second request starts only after the response handshake plus an idle cycle.
REQ-028 rst_ni pulsed low in the 3rd request cycle -> request outputs drop immediately, no response is produced, and cmd_ready_o=1 after release.
REQ-029 ack_i and err_i asserted in the same cycle with the macro undefined -> RSP_ERR immediately and retries 0.
